clock_divider_multi: RTL and testbench

- Multi-channel programmable clock divider. Generalises the fixed single-divisor divider to NUM_CH independent channels, each with a runtime divisor and high-time.
- Per-channel enable and tick strobe; registered, glitch-free outputs.
- Divisor/high-time updates are shadowed and applied only at a period boundary.
- Sits between the board oscillator and slow FPGA logic (LED blink, UART baud, debounce sampling).

---
 rtl/clkdiv_pkg.sv | 31 +++
 rtl/clock_divider_channel.sv | 95 +++++++++
 rtl/clock_divider_multi.sv | 78 +++++++
 tb/tb_clock_divider_multi.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared constants, config payload and output-compare helper for the
// multi-channel clock divider.
package clkdiv_pkg;

    localparam int unsigned CLKDIV_CNT_W        = 32;
    localparam int unsigned CLKDIV_DEFAULT_DIV  = 100000000;
    localparam int unsigned CLKDIV_DEFAULT_HIGH = 50000000;

    // Divisor / high-time pair held in both the active and shadow registers
    typedef struct packed {
        logic [CLKDIV_CNT_W-1:0] div;
        logic [CLKDIV_CNT_W-1:0] high;
    } clkdiv_cfg_t;

    // High phase sits at the end of the period: cnt >= div - high.
    // The explicit high >= div case avoids the subtraction underflowing.
    function automatic logic clkdiv_out_high(input logic [CLKDIV_CNT_W-1:0] cnt,
                                             input logic [CLKDIV_CNT_W-1:0] div,
                                             input logic [CLKDIV_CNT_W-1:0] high);
        logic res;
        if (high == '0) begin
            res = 1'b0;
        end else if (high >= div) begin
            res = 1'b1;
        end else begin
            res = (cnt >= (div - high));
        end
        return res;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: period counter, active and shadow config, pending
// flag, registered clk_out / tick.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   en                run enable; low forces the counter to 0
//   sync_req          force counter to 0 and apply pending shadow
//   wr_en, wr_div,
//   wr_high           shadow write (ignored while pending)
//   clk_out, tick     registered divided clock and per-period strobe
//   pending           shadow waiting for a period boundary
module clock_divider_channel
    import clkdiv_pkg::*;
#(
    parameter logic [CLKDIV_CNT_W-1:0] RST_DIV  = CLKDIV_CNT_W'(CLKDIV_DEFAULT_DIV),
    parameter logic [CLKDIV_CNT_W-1:0] RST_HIGH = CLKDIV_CNT_W'(CLKDIV_DEFAULT_HIGH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    sync_req,
    input  logic                    wr_en,
    input  logic [CLKDIV_CNT_W-1:0] wr_div,
    input  logic [CLKDIV_CNT_W-1:0] wr_high,
    output logic                    clk_out,
    output logic                    tick,
    output logic                    pending
);

    logic [CLKDIV_CNT_W-1:0] cnt_q, cnt_d;
    clkdiv_cfg_t             act_q, act_d;
    clkdiv_cfg_t             shd_q, shd_d;
    logic                    pend_q, pend_d;
    logic                    clk_out_q, clk_out_d;
    logic                    tick_q, tick_d;

    logic run;
    logic boundary;

    assign run      = en && (act_q.div != '0);
    assign boundary = run && (cnt_q == (act_q.div - CLKDIV_CNT_W'(1)));

    // Next-state: counter, outputs from current count, shadow apply/write
    always_comb begin
        cnt_d     = cnt_q;
        act_d     = act_q;
        shd_d     = shd_q;
        pend_d    = pend_q;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;

        if (!run || boundary || sync_req) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CLKDIV_CNT_W'(1);
        end

        clk_out_d = run && clkdiv_out_high(cnt_q, act_q.div, act_q.high);
        // A forced phase restart is not a natural period end
        tick_d    = boundary && !sync_req;

        // Apply only at a safe point; the new values steer the counter next cycle
        if (pend_q && (boundary || !en || (act_q.div == '0) || sync_req)) begin
            act_d  = shd_q;
            pend_d = 1'b0;
        end else if (wr_en && !pend_q) begin
            shd_d.div  = wr_div;
            shd_d.high = wr_high;
            pend_d     = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            act_q     <= '{div: RST_DIV, high: RST_HIGH};
            shd_q     <= '{div: RST_DIV, high: RST_HIGH};
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            shd_q     <= shd_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider top: config decode, cfg_ready
// mux and NUM_CH divider channels.
// Optional macro CLKDIV_PHASE_SYNC_EN adds sync_req, which restarts every
// enabled channel at counter 0 on the next edge.
// Ports:
//   clock_in, reset_n   clock, synchronous active-low reset
//   sync_req            (CLKDIV_PHASE_SYNC_EN only) phase-align all channels
//   ch_en               per-channel run enable
//   cfg_valid/ready     config handshake; cfg_ready = ~pending[cfg_ch]
//   cfg_ch, cfg_div,
//   cfg_high            target channel and new divisor / high-time
//   clk_out, tick       registered divided clocks and period strobes
//   pending             per-channel shadow waiting to apply
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter  int unsigned NUM_CH       = 4,
    parameter  int unsigned CNT_W        = CLKDIV_CNT_W,
    parameter  int unsigned DEFAULT_DIV  = CLKDIV_DEFAULT_DIV,
    parameter  int unsigned DEFAULT_HIGH = CLKDIV_DEFAULT_HIGH,
    localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock_in,
    input  logic              reset_n,
`ifdef CLKDIV_PHASE_SYNC_EN
    input  logic              sync_req,
`endif
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    logic [NUM_CH-1:0] wr_en;
    logic              sync_w;

`ifdef CLKDIV_PHASE_SYNC_EN
    assign sync_w = sync_req;
`else
    assign sync_w = 1'b0;
`endif

    // Channel select decode; out-of-range channels read as ready and drop
    always_comb begin
        wr_en     = '0;
        cfg_ready = 1'b1;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pending[i];
                wr_en[i]  = cfg_valid & ~pending[i];
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        clock_divider_channel #(
            .RST_DIV  (CLKDIV_CNT_W'(DEFAULT_DIV)),
            .RST_HIGH (CLKDIV_CNT_W'(DEFAULT_HIGH))
        ) u_ch (
            .clk      (clock_in),
            .rst_n    (reset_n),
            .en       (ch_en[g]),
            .sync_req (sync_w),
            .wr_en    (wr_en[g]),
            .wr_div   (CLKDIV_CNT_W'(cfg_div)),
            .wr_high  (CLKDIV_CNT_W'(cfg_high)),
            .clk_out  (clk_out[g]),
            .tick     (tick[g]),
            .pending  (pending[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi (NUM_CH=2, DEFAULT_DIV=4,
// DEFAULT_HIGH=2); expected per-cycle outputs are hand-traced.
module tb_clock_divider_multi;

    logic        clock_in = 1'b0;
    logic        reset_n;
    logic        sync_req;
    logic [1:0]  ch_en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [0:0]  cfg_ch;
    logic [31:0] cfg_div;
    logic [31:0] cfg_high;
    logic [1:0]  clk_out;
    logic [1:0]  tick;
    logic [1:0]  pending;

    int chk_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    always #5 clock_in = ~clock_in;

    clock_divider_multi #(
        .NUM_CH       (2),
        .CNT_W        (32),
        .DEFAULT_DIV  (4),
        .DEFAULT_HIGH (2)
    ) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
`ifdef CLKDIV_PHASE_SYNC_EN
        .sync_req  (sync_req),
`endif
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1ns later, then drop one-shot inputs
    task automatic next_edge();
        @(posedge clock_in);
        #1;
        cyc++;
    endtask

    task automatic clear_pulses();
        cfg_valid = 1'b0;
        sync_req  = 1'b0;
    endtask

    task automatic step(input logic [1:0] ec, input logic [1:0] et, input logic [1:0] ep);
        next_edge();
        check($sformatf("cyc%0d clk_out", cyc), 32'(clk_out), 32'(ec));
        check($sformatf("cyc%0d tick", cyc),    32'(tick),    32'(et));
        check($sformatf("cyc%0d pending", cyc), 32'(pending), 32'(ep));
        clear_pulses();
    endtask

    task automatic cfg_write(input logic ch, input logic [31:0] div, input logic [31:0] high);
        cfg_ch    = ch;
        cfg_div   = div;
        cfg_high  = high;
        cfg_valid = 1'b1;
        #1;
        check($sformatf("cyc%0d cfg_ready", cyc), 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        sync_req  = 1'b0;
        ch_en     = 2'b00;
        cfg_valid = 1'b0;
        cfg_ch    = 1'b0;
        cfg_div   = '0;
        cfg_high  = '0;
        next_edge();
        next_edge();
        check("rst clk_out", 32'(clk_out), 32'd0);
        check("rst tick",    32'(tick),    32'd0);
        check("rst pending", 32'(pending), 32'd0);
        check("rst ready",   32'(cfg_ready), 32'd1);

        // Default div=4 high=2 on both channels
        reset_n = 1'b1;
        ch_en   = 2'b11;
        step(2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        step(2'b11, 2'b00, 2'b00);
        step(2'b11, 2'b11, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        step(2'b11, 2'b00, 2'b00);
        step(2'b11, 2'b11, 2'b00);

        // Mid-period shadow write ch0 div=6 high=1
        cfg_write(1'b0, 32'd6, 32'd1);
        step(2'b00, 2'b00, 2'b01);
        check("busy ready ch0", 32'(cfg_ready), 32'd0);
        cfg_ch = 1'b1;
        #1;
        check("idle ready ch1", 32'(cfg_ready), 32'd1);
        // Attempted write while busy must be dropped
        cfg_ch    = 1'b0;
        cfg_div   = 32'd2;
        cfg_high  = 32'd2;
        cfg_valid = 1'b1;
        step(2'b00, 2'b00, 2'b01);
        step(2'b11, 2'b00, 2'b01);
        step(2'b11, 2'b11, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        step(2'b10, 2'b00, 2'b00);
        step(2'b10, 2'b10, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        step(2'b01, 2'b01, 2'b00);
        step(2'b10, 2'b00, 2'b00);
        step(2'b10, 2'b10, 2'b00);

        // div=0 stalls ch0
        cfg_write(1'b0, 32'd0, 32'd0);
        step(2'b00, 2'b00, 2'b01);
        step(2'b00, 2'b00, 2'b01);
        step(2'b10, 2'b00, 2'b01);
        step(2'b11, 2'b11, 2'b00);
        step(2'b00, 2'b00, 2'b00);

        // div=1 high=1 applied immediately from the stalled state
        cfg_write(1'b0, 32'd1, 32'd1);
        step(2'b00, 2'b00, 2'b01);
        step(2'b10, 2'b00, 2'b00);
        step(2'b11, 2'b11, 2'b00);
        step(2'b01, 2'b01, 2'b00);
        step(2'b01, 2'b01, 2'b00);
        step(2'b11, 2'b01, 2'b00);
        step(2'b11, 2'b11, 2'b00);

        // high=0: clk_out stays low, tick persists
        cfg_write(1'b0, 32'd4, 32'd0);
        step(2'b01, 2'b01, 2'b01);
        step(2'b01, 2'b01, 2'b00);
        step(2'b10, 2'b00, 2'b00);
        step(2'b10, 2'b10, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b01, 2'b00);
        step(2'b10, 2'b00, 2'b00);

        // Drop ch1 mid-high phase, then re-enable
        ch_en = 2'b01;
        step(2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        ch_en = 2'b11;
        step(2'b00, 2'b01, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        step(2'b10, 2'b00, 2'b00);
        step(2'b10, 2'b10, 2'b00);
        step(2'b00, 2'b01, 2'b00);

        // Reset with pending set discards the shadow
        cfg_write(1'b0, 32'd9, 32'd3);
        step(2'b00, 2'b00, 2'b01);
        reset_n = 1'b0;
        step(2'b00, 2'b00, 2'b00);
        reset_n = 1'b1;
        step(2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        step(2'b11, 2'b00, 2'b00);
        step(2'b11, 2'b11, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00);
        step(2'b11, 2'b00, 2'b00);
        step(2'b11, 2'b11, 2'b00);

`ifdef CLKDIV_PHASE_SYNC_EN
        // ch0 div=4, ch1 div=8, then phase-align
        begin
            int wait_cyc;
            cfg_write(1'b1, 32'd8, 32'd4);
            next_edge();
            clear_pulses();
            wait_cyc = 0;
            while (pending != 2'b00 && wait_cyc < 20) begin
                next_edge();
                wait_cyc++;
            end
            check("sync pending drained", 32'(pending), 32'd0);
            next_edge();
            sync_req = 1'b1;
            next_edge();
            clear_pulses();
            for (int k = 1; k <= 16; k++) begin
                next_edge();
                check($sformatf("sync+%0d tick0", k), 32'(tick[0]), 32'((k % 4) == 0));
                check($sformatf("sync+%0d tick1", k), 32'(tick[1]), 32'((k % 8) == 0));
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
